// File: rtl/maxnet_controller_if.sv
// rtl/maxnet_controller_if.sv - host handshake and PLU datapath control bundle for the Maxnet controller
interface maxnet_controller_if #(
  parameter int ITER_W = 6
);
  logic              start;
  logic              busy;
  logic              done;
  logic              timeout;
  logic              stall;
  logic [ITER_W-1:0] iter_count;
  logic              mux_sel;
  logic              we_prim;
  logic              we_a_reg;
  logic              rst_plu;
  logic              plu_start;
  logic              plu_done;
  logic              finish;

  modport master (
    input  start, plu_done, finish,
    output busy, done, timeout, stall, iter_count,
    output mux_sel, we_prim, we_a_reg, rst_plu, plu_start
  );

  modport slave (
    output start, plu_done, finish,
    input  busy, done, timeout, stall, iter_count,
    input  mux_sel, we_prim, we_a_reg, rst_plu, plu_start
  );
endinterface

// File: rtl/maxnet_controller.sv
// rtl/maxnet_controller.sv - sequencing FSM for the four-PLU Maxnet datapath with iteration and stall watchdogs
module maxnet_controller #(
  parameter int MAX_ITER = 32,
  parameter int ITER_W   = 6,
  parameter int PLU_TMO  = 64,
  parameter int TMO_W    = 7
) (
  input  logic                clk,
  input  logic                rst,
  maxnet_controller_if.master bus
);
  typedef enum logic [2:0] {
    S_IDLE, S_LOAD, S_CLR, S_RUN, S_WAIT, S_UPDATE, S_DONE
  } state_e;

  state_e            state_q, state_d;
  logic [ITER_W-1:0] iter_q, iter_d, iter_inc;
  logic [TMO_W-1:0]  wdog_q, wdog_d;
  logic              finish_q, finish_d;
  logic              timeout_q, timeout_d;
  logic              stall_q, stall_d;
  logic              busy_q, done_q, mux_sel_q, we_prim_q, we_a_reg_q, rst_plu_q, plu_start_q;

  assign iter_inc = iter_q + 1'b1;

  always_comb begin
    state_d   = state_q;
    iter_d    = iter_q;
    wdog_d    = wdog_q;
    finish_d  = finish_q;
    timeout_d = timeout_q;
    stall_d   = stall_q;
    case (state_q)
      S_IDLE: begin
        if (bus.start) begin
          state_d   = S_LOAD;
          iter_d    = '0;
          timeout_d = 1'b0;
          stall_d   = 1'b0;
        end
      end
      S_LOAD: state_d = S_CLR;
      S_CLR: begin
        wdog_d  = '0;
        state_d = S_RUN;
      end
      S_RUN: state_d = S_WAIT;
      S_WAIT: begin
        // A completion arriving on the last watchdog cycle still wins.
        if (bus.plu_done) begin
          finish_d = bus.finish;
          state_d  = S_UPDATE;
        end else if (wdog_q == TMO_W'(PLU_TMO - 1)) begin
          state_d   = S_DONE;
          timeout_d = 1'b1;
          stall_d   = 1'b1;
        end else begin
          wdog_d = wdog_q + 1'b1;
        end
      end
      S_UPDATE: begin
        if (iter_q != ITER_W'(MAX_ITER)) iter_d = iter_inc;
        if (finish_q) begin
          state_d = S_DONE;
        end else if (iter_inc == ITER_W'(MAX_ITER)) begin
          state_d   = S_DONE;
          timeout_d = 1'b1;
        end else begin
          state_d = S_CLR;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Strobes are decoded from the next state so they line up with the state they belong to.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      iter_q      <= '0;
      wdog_q      <= '0;
      finish_q    <= 1'b0;
      timeout_q   <= 1'b0;
      stall_q     <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      mux_sel_q   <= 1'b0;
      we_prim_q   <= 1'b0;
      we_a_reg_q  <= 1'b0;
      rst_plu_q   <= 1'b1;
      plu_start_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      iter_q      <= iter_d;
      wdog_q      <= wdog_d;
      finish_q    <= finish_d;
      timeout_q   <= timeout_d;
      stall_q     <= stall_d;
      busy_q      <= (state_d != S_IDLE);
      done_q      <= (state_q == S_DONE);
      mux_sel_q   <= (state_d == S_UPDATE);
      we_prim_q   <= (state_d == S_LOAD);
      we_a_reg_q  <= (state_d == S_LOAD) || (state_d == S_UPDATE);
      rst_plu_q   <= (state_d == S_CLR);
      plu_start_q <= (state_d == S_RUN);
    end
  end

  assign bus.busy       = busy_q;
  assign bus.done       = done_q;
  assign bus.timeout    = timeout_q;
  assign bus.stall      = stall_q;
  assign bus.iter_count = iter_q;
  assign bus.mux_sel    = mux_sel_q;
  assign bus.we_prim    = we_prim_q;
  assign bus.we_a_reg   = we_a_reg_q;
  assign bus.rst_plu    = rst_plu_q;
  assign bus.plu_start  = plu_start_q;
endmodule

// File: tb/tb_maxnet_controller.sv
// tb/tb_maxnet_controller.sv - scoreboard bench for maxnet_controller with a randomized PLU responder
module tb_maxnet_controller;
  localparam int MAX_ITER = 4;
  localparam int ITER_W   = 6;
  localparam int PLU_TMO  = 8;
  localparam int TMO_W    = 7;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  maxnet_controller_if #(.ITER_W(ITER_W)) bus ();

  maxnet_controller #(
    .MAX_ITER(MAX_ITER), .ITER_W(ITER_W), .PLU_TMO(PLU_TMO), .TMO_W(TMO_W)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  typedef struct {
    int iter; int tmo; int stl; int ps; int wa; int lat;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;
  int   n_checks = 0;
  int   n_pass   = 0;
  int   cyc      = 0;
  int   plan_f, plan_k;
  int   plan_d [1:8];
  logic [6:0] tv [1:7];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input int act, input int req);
    n_checks++;
    if (act == req) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", name, act, req);
  endtask

  // Outcome of one run from the plan: which iteration finishes, which one stalls, PLU delays.
  function automatic exp_t model();
    exp_t e;
    int   s;
    e = '{default: 0};
    s = 0;
    for (int i = 1; i <= MAX_ITER; i++) begin
      e.ps = i;
      if (i == plan_k) begin
        s += 2 + PLU_TMO;
        e.wa = i; e.iter = i - 1; e.tmo = 1; e.stl = 1;
        break;
      end
      s += 4 + plan_d[i];
      e.wa = 1 + i; e.iter = i;
      if (i == plan_f) break;
      if (i == MAX_ITER) e.tmo = 1;
    end
    e.lat = s + 2;
    return e;
  endfunction

  // PLU responder: plu_done d+1 cycles after plu_start, finish noise everywhere else.
  int r_idx = 0, r_cnt = 0;
  bit r_pend = 0, r_fin = 0;
  initial begin
    bus.plu_done = 1'b0;
    bus.finish   = 1'b0;
    forever begin
      @(negedge clk);
      bus.plu_done = 1'b0;
      bus.finish   = 1'($urandom);
      if (rst || !bus.busy) begin
        r_idx = 0; r_pend = 0;
      end else begin
        if (r_pend) begin
          if (r_cnt == 0) begin
            bus.plu_done = 1'b1; bus.finish = r_fin; r_pend = 0;
          end else r_cnt--;
        end
        if (bus.plu_start) begin
          r_idx++;
          if (r_idx != plan_k && r_idx <= 8) begin
            r_pend = 1; r_cnt = plan_d[r_idx]; r_fin = (r_idx == plan_f);
          end
        end
      end
    end
  end

  // Monitor: counts strobes per run and checks each done pulse against the scoreboard.
  int m_ps = 0, m_wa = 0, t_busy = 0;
  bit prev_busy = 0;
  initial begin
    forever begin
      @(negedge clk);
      if (rst) begin
        m_ps = 0; m_wa = 0; prev_busy = 0;
      end else begin
        if (bus.busy && !prev_busy) t_busy = cyc;
        if (bus.plu_start) m_ps++;
        if (bus.we_a_reg) m_wa++;
        if (bus.done) begin
          if (exp_q.size() == 0) chk("unexpected_done", 1, 0);
          else begin
            mon_e = exp_q.pop_front();
            chk("iter_count", int'(bus.iter_count), mon_e.iter);
            chk("timeout", int'(bus.timeout), mon_e.tmo);
            chk("stall", int'(bus.stall), mon_e.stl);
            chk("plu_start_pulses", m_ps, mon_e.ps);
            chk("we_a_reg_pulses", m_wa, mon_e.wa);
            chk("latency", cyc - t_busy, mon_e.lat);
            chk("busy_at_done", int'(bus.busy), 0);
          end
          m_ps = 0; m_wa = 0;
        end
        prev_busy = bus.busy;
      end
    end
  end

  task automatic set_plan(input int f, input int k, input int dmin, input int dmax);
    plan_f = f; plan_k = k;
    for (int i = 1; i <= 8; i++) plan_d[i] = int'($urandom_range(dmax, dmin));
  endtask

  task automatic launch(input bit push);
    if (push) exp_q.push_back(model());
    @(negedge clk); bus.start = 1'b1;
    @(negedge clk); bus.start = 1'b0;
  endtask

  task automatic wait_done();
    int n = 0;
    while (exp_q.size() != 0 && n < 500) begin @(negedge clk); n++; end
    if (exp_q.size() != 0) begin chk("done_wait_bound", 0, 1); exp_q.delete(); end
    @(negedge clk);
  endtask

  initial begin
    #500000;
    $display("FAIL global_time_limit: got running, expected finished");
    $fatal(1);
  end

  initial begin
    int n, seen, dones;
    tv[1] = 7'b1011000; tv[2] = 7'b1000010; tv[3] = 7'b1000001; tv[4] = 7'b1000000;
    tv[5] = 7'b1001100; tv[6] = 7'b1000000; tv[7] = 7'b0100000;
    rst = 1'b1; bus.start = 1'b0;
    set_plan(1, 0, 0, 0);
    repeat (3) @(negedge clk);
    chk("reset_strobes", int'({bus.busy, bus.done, bus.we_prim, bus.we_a_reg, bus.mux_sel, bus.plu_start}), 0);
    chk("reset_flags", int'({bus.timeout, bus.stall}), 0);
    chk("reset_rst_plu", int'(bus.rst_plu), 1);
    chk("reset_iter", int'(bus.iter_count), 0);
    rst = 1'b0;
    @(negedge clk);
    chk("rst_plu_released", int'(bus.rst_plu), 0);

    // Single-iteration win, cycle by cycle: {busy,done,we_prim,we_a_reg,mux_sel,rst_plu,plu_start}
    exp_q.push_back(model());
    bus.start = 1'b1;
    for (int t = 1; t <= 7; t++) begin
      @(negedge clk);
      bus.start = 1'b0;
      chk($sformatf("timing_c%0d", t),
          int'({bus.busy, bus.done, bus.we_prim, bus.we_a_reg, bus.mux_sel, bus.rst_plu, bus.plu_start}),
          int'(tv[t]));
    end
    wait_done();

    set_plan(3, 0, 0, 3); launch(1); wait_done();
    set_plan(0, 0, 0, 2); launch(1); wait_done();
    set_plan(MAX_ITER, 0, 0, 1); launch(1); wait_done();

    // PLU stall, then sticky flags until the next accepted start.
    set_plan(0, 1, 0, 0); launch(1); wait_done();
    repeat (3) @(negedge clk);
    chk("timeout_holds", int'(bus.timeout), 1);
    chk("stall_holds", int'(bus.stall), 1);
    set_plan(1, 0, 0, 0); launch(1);
    chk("timeout_cleared", int'(bus.timeout), 0);
    chk("stall_cleared", int'(bus.stall), 0);
    wait_done();

    // start pulsed during WAIT must not queue a second run.
    set_plan(1, 0, 0, 0); plan_d[1] = 3; launch(1);
    repeat (3) @(negedge clk);
    bus.start = 1'b1; @(negedge clk); bus.start = 1'b0;
    wait_done();
    repeat (5) @(negedge clk);
    chk("start_in_wait_ignored", int'(bus.busy), 0);

    // start held high: back-to-back runs.
    set_plan(2, 0, 0, 2);
    exp_q.push_back(model()); exp_q.push_back(model());
    @(negedge clk); bus.start = 1'b1;
    n = 0;
    while (exp_q.size() > 1 && n < 500) begin @(negedge clk); n++; end
    @(negedge clk);
    chk("back_to_back_restart", int'(bus.busy), 1);
    bus.start = 1'b0;
    wait_done();

    for (int r = 0; r < 30; r++) begin
      set_plan(int'($urandom_range(5, 0)),
               ($urandom_range(4, 0) == 0) ? int'($urandom_range(MAX_ITER, 1)) : 0, 0, 3);
      launch(1);
      wait_done();
    end

    // Reset during WAIT of iteration 2.
    set_plan(0, 0, 2, 2); launch(0);
    seen = 0; n = 0;
    while (seen < 2 && n < 200) begin
      @(negedge clk); n++;
      if (bus.plu_start) seen++;
    end
    chk("second_plu_start_seen", seen, 2);
    @(negedge clk); rst = 1'b1;
    @(negedge clk);
    chk("midrun_reset_busy", int'(bus.busy), 0);
    chk("midrun_reset_iter", int'(bus.iter_count), 0);
    rst = 1'b0;
    dones = 0;
    for (int t = 0; t < 12; t++) begin
      @(negedge clk);
      if (bus.done) dones++;
    end
    chk("midrun_reset_no_done", dones, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule

// File: doc/maxnet_controller.md
Name: maxnet_controller

Overview:
- Control FSM that drives the Maxnet four-PLU datapath and consumes its status (`plu_done`, `finish`).
- Sequences: load initial activations and epsilon, reset PLUs, start an iteration, wait for all PLUs, write back, test for a single winner, repeat.
- Presents a start/busy/done handshake to the host, with iteration-limit and PLU-stall watchdogs.

Parameters:
- MAX_ITER, 32, maximum competition iterations before abort (1..2^ITER_W-1).
- ITER_W, 6, width of iteration counter.
- PLU_TMO, 64, max cycles spent in WAIT for `plu_done` before abort.
- TMO_W, 7, width of watchdog counter.

Ports:
- clk  in  1  clock, all logic on rising edge
- rst  in  1  synchronous reset, active-high
- start  in  1  host request; sampled only in IDLE
- busy  out  1  high in every state except IDLE
- done  out  1  one-cycle pulse on entering IDLE from DONE
- timeout  out  1  high with `done` if aborted (iteration limit or PLU stall); holds until next accepted start
- stall  out  1  high with `timeout` when the cause was a PLU stall; holds until next accepted start
- iter_count  out  ITER_W  completed iterations of current/last run
- mux_sel  out  1  0 selects `a*_init` into A registers, 1 selects PLU outputs
- we_prim  out  1  write enable for epsilon and a*_prim copies
- we_a_reg  out  1  write enable for A registers
- rst_plu  out  1  synchronous clear to all four PLUs
- plu_start  out  1  one-cycle start pulse to all PLUs
- plu_done  in  1  AND of the four PLU done flags
- finish  in  1  OutputCheck valid: exactly one nonzero activation

Behaviour:
- Reset: state=IDLE; busy, done, timeout, stall, mux_sel, we_prim, we_a_reg, plu_start = 0; rst_plu=1 during reset cycle; iter_count=0. Reset mid-run aborts immediately with no `done` pulse.
- All outputs are registered Moore decodes of state, except the counters.
- States:
  - IDLE: `start`=1 → LOAD. On acceptance, clear iter_count, timeout and stall.
  - LOAD (1 cycle): we_prim=1, mux_sel=0, we_a_reg=1 → CLR.
  - CLR (1 cycle): rst_plu=1; clear watchdog → RUN.
  - RUN (1 cycle): plu_start=1 → WAIT.
  - WAIT: watchdog increments each cycle.
    - `plu_done`=1 → UPDATE, latch finish_q=`finish`.
    - Else if watchdog reaches PLU_TMO-1 → DONE with timeout=1, stall=1.
    - `plu_done` has priority over the watchdog in the same cycle.
  - UPDATE (1 cycle): mux_sel=1, we_a_reg=1, iter_count+=1.
    - finish_q=1 → DONE.
    - Else if new iter_count==MAX_ITER → DONE with timeout=1.
    - Else → CLR.
    - finish_q has priority over the limit when both hold.
  - DONE (1 cycle): → IDLE; `done`=1 in the first IDLE cycle.
- `start` held high across DONE→IDLE begins a new run on the cycle after the `done` pulse; it is not lost or double-counted.
- `start` outside IDLE is ignored (no queuing).
- `finish` and `plu_done` are ignored in every state except WAIT.
- iter_count saturates at MAX_ITER, never wraps.
- Latency from start (cycle 0) with `plu_done` on the first WAIT cycle:
  - LOAD=1, CLR=2, RUN=3, WAIT=4, UPDATE=5, then CLR=6 (next iteration) or DONE=6 / done pulse=7.
  - Each extra iteration costs 4 cycles plus PLU wait cycles.

Test Plan:
- Single-iteration win: a=(5,1,1,1), eps=0.25, `plu_done` and `finish` raised at cycle 4 → we_prim/we_a_reg at cycle 1, rst_plu at 2, plu_start at 3, we_a_reg+mux_sel=1 at 5, `done`=1 at cycle 7, iter_count=1, timeout=0.
- Multi-iteration: `finish` asserted only on the 3rd `plu_done` → exactly 3 plu_start pulses, 4 we_a_reg pulses (1 load, 3 update), iter_count=3, `done` once.
- Iteration limit (MAX_ITER=4): `finish` never high → `done` with timeout=1, stall=0, iter_count=4, no 5th plu_start.
- PLU stall (PLU_TMO=8): `plu_done` held 0 → DONE after 8 WAIT cycles, timeout=1, stall=1, no we_a_reg pulse after load.
- Handshake edges:
  - `start` pulsed during WAIT → ignored.
  - `start` held continuously → back-to-back runs, each separated by one IDLE cycle with `done`=1.
  - Next accepted start clears timeout and stall.
- Reset mid-run: rst asserted in WAIT of iteration 2 → next cycle state IDLE, busy=0, iter_count=0, `done` never pulses.
